// File: rtl/gpio_param.sv
// gpio_param: register-mapped GPIO block with per-input synchronizer and
// debounce, edge-triggered sticky status, output register and an
// active-low interrupt.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   CS_N, RD_N     active-low chip select / read strobe
//   WR_N           active-low write strobe
//   Addr[11:0]     byte offset
//   DataIn[31:0]   write data
//   DataOut[31:0]  combinational read data (0 when not reading)
//   in_pins        raw asynchronous inputs, N_IN wide
//   out_pins       OUT register, N_OUT wide
//   Intr           active-low interrupt
//
// Register map
//   0x00 IN_LEVEL (RO)  0x04 STATUS (RO, W1C)  0x08 RISE_EN  0x0C FALL_EN
//   0x10 OUT            0x14 IRQ_MASK
//
// Build option: define GPIO_PARAM_IRQ_MASK_EN to implement IRQ_MASK as a
// read/write register. Without it 0x14 reads 0, writes are dropped and every
// STATUS bit drives the interrupt.

// One input lane: 2-flop synchronizer followed by a debounce counter.
// toggle is combinational so the parent can set STATUS on the very edge
// where level flips.
module gpio_param_lane #(
   parameter int DEB_CYCLES = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic toggle
);
   logic       sync1, sync2;
   logic [7:0] cnt;

   // the edge on which the count would reach DEB_CYCLES flips the level
   assign toggle = (sync2 != level) && (cnt == 8'(DEB_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= 8'd0;
         level <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         if (toggle) begin
            level <= ~level;
            cnt   <= 8'd0;
         end else if (sync2 != level) begin
            cnt <= cnt + 8'd1;
         end else begin
            cnt <= 8'd0;
         end
      end
   end
endmodule

module gpio_param #(
   parameter int          N_IN       = 12,
   parameter int          N_OUT      = 10,
   parameter int          DEB_CYCLES = 15,
   parameter logic [31:0] OUT_RST    = 32'h0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              CS_N,
   input  logic              RD_N,
   input  logic              WR_N,
   input  logic [11:0]       Addr,
   input  logic [31:0]       DataIn,
   output logic [31:0]       DataOut,
   input  logic [N_IN-1:0]   in_pins,
   output logic [N_OUT-1:0]  out_pins,
   output logic              Intr
);
   logic [N_IN-1:0]  level, toggle, set, clr;
   logic [N_IN-1:0]  status, rise_en, fall_en, irq_mask;
   logic [N_OUT-1:0] out_reg;
   logic             we;
   logic             unused_data;

   gpio_param_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane [N_IN-1:0] (
      .clk    (clk),
      .reset  (reset),
      .pin    (in_pins),
      .level  (level),
      .toggle (toggle)
   );

   assign we = !CS_N && !WR_N;

   // level still holds the pre-toggle value here: 0 means a rising edge
   assign set = toggle & ((~level & rise_en) | (level & fall_en));
   assign clr = (we && Addr == 12'h004) ? DataIn[N_IN-1:0] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         status  <= '0;
         rise_en <= '0;
         fall_en <= '0;
         out_reg <= OUT_RST[N_OUT-1:0];
      end else begin
         // OR-ing set after the clear lets a simultaneous set win
         status <= (status & ~clr) | set;
         if (we && Addr == 12'h008) rise_en <= DataIn[N_IN-1:0];
         if (we && Addr == 12'h00C) fall_en <= DataIn[N_IN-1:0];
         if (we && Addr == 12'h010) out_reg <= DataIn[N_OUT-1:0];
      end
   end

`ifdef GPIO_PARAM_IRQ_MASK_EN
   always_ff @(posedge clk) begin
      if (reset)                         irq_mask <= '1;
      else if (we && Addr == 12'h014)    irq_mask <= DataIn[N_IN-1:0];
   end
`else
   assign irq_mask = '1;
`endif

   always_comb begin
      DataOut = '0;
      if (!CS_N && !RD_N) begin
         case (Addr)
            12'h000: DataOut = 32'(level);
            12'h004: DataOut = 32'(status);
            12'h008: DataOut = 32'(rise_en);
            12'h00C: DataOut = 32'(fall_en);
            12'h010: DataOut = 32'(out_reg);
`ifdef GPIO_PARAM_IRQ_MASK_EN
            12'h014: DataOut = 32'(irq_mask);
`endif
            default: DataOut = '0;
         endcase
      end
   end

   assign out_pins = out_reg;
   assign Intr     = ~|(status & irq_mask);

   // DataIn bits above the register widths have no destination
   assign unused_data = ^DataIn;
endmodule

// File: doc/gpio_param.md
GPIO_PARAM -- requirements
Module: gpio_param

Interface
REQ-001 Parameter N_IN, default 12, number of inputs (1..32).
REQ-002 Parameter N_OUT, default 10, number of outputs (1..32).
REQ-003 Parameter DEB_CYCLES, default 15, debounce stability count (1..255).
REQ-004 Parameter OUT_RST, default 32'h0, reset value of OUT register.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 CS_N  input  1  active-low chip select.
REQ-008 RD_N  input  1  active-low read strobe.
REQ-009 WR_N  input  1  active-low write strobe.
REQ-010 Addr  input  12  byte offset.
REQ-011 DataIn  input  32  write data.
REQ-012 DataOut  output  32  read data, combinational.
REQ-013 in_pins  input  N_IN  asynchronous raw inputs.
REQ-014 out_pins  output  N_OUT  OUT[N_OUT-1:0].
REQ-015 Intr  output  1  active-low interrupt.

Function
REQ-016 Register map: 0x00 IN_LEVEL (RO), 0x04 STATUS (RO; W1C), 0x08 RISE_EN (RW), 0x0C FALL_EN (RW), 0x10 OUT (RW), 0x14 IRQ_MASK (RW; see REQ-031).
REQ-017 Each in_pins bit passes a 2-flop synchronizer before debounce.
REQ-018 Each input has its own 8-bit counter: it increments while the synchronized value differs from the debounced level and clears when they are equal.
REQ-019 The debounced level toggles, and the counter clears, on the edge where the counter would reach DEB_CYCLES.
REQ-020 Latency: a raw level held stable from sampling edge k appears in IN_LEVEL after edge k+1+DEB_CYCLES; a glitch shorter than DEB_CYCLES synchronized cycles produces no change.
REQ-021 A debounced 0->1 transition with RISE_EN[i]=1, or a 1->0 transition with FALL_EN[i]=1, sets STATUS[i] on the same edge the level updates.
REQ-022 STATUS bits are sticky; a write to 0x04 clears each bit where DataIn is 1; bits written 0 are unchanged.
REQ-023 If a set and a W1C clear hit the same bit in the same cycle, the set wins.
REQ-024 Reads have no side effects; DataOut is 0 when CS_N or RD_N is high, for unmapped offsets, and in bits at or above N_IN/N_OUT.
REQ-025 A write occurs when CS_N=0 and WR_N=0; the new value is visible on the next cycle; writes to 0x00 or unmapped offsets are ignored.
REQ-026 Intr = ~|(STATUS & IRQ_MASK), combinational from registers; it falls the cycle after the setting edge and rises the cycle after the clearing write.

Reset
REQ-027 On reset: synchronizers, counters, IN_LEVEL, STATUS, RISE_EN and FALL_EN clear to 0.
REQ-028 On reset: OUT loads OUT_RST, IRQ_MASK loads all ones in bits [N_IN-1:0], and Intr=1.
REQ-029 Reset asserted mid-debounce discards the partial count; no STATUS bit sets during or on the edge of reset.
REQ-030 After reset, inputs held high debounce to IN_LEVEL=1 without setting STATUS, because RISE_EN=0.

Configuration
REQ-031 With GPIO_PARAM_IRQ_MASK_EN defined: IRQ_MASK is implemented as read/write at 0x14.
REQ-032 Without GPIO_PARAM_IRQ_MASK_EN: 0x14 reads 0, writes to it are ignored, and Intr = ~|STATUS.

Verification (N_IN=12, N_OUT=10, DEB_CYCLES=4)
REQ-033 Reset then idle -> DataOut=0 at every offset except OUT=OUT_RST; Intr=1; out_pins=OUT_RST[9:0].
REQ-034 RISE_EN=0x001, in_pins[0] 0->1 held -> IN_LEVEL=0x001 and STATUS=0x001 after edge k+5; Intr=0 the following cycle; W1C 0x001 -> Intr=1.
REQ-035 in_pins[3] pulses high for 3 cycles with FALL_EN=RISE_EN=0xFFF -> IN_LEVEL and STATUS stay 0.
REQ-036 STATUS[0] setting edge coincides with a W1C of 0x001 -> STATUS[0]=1 and Intr=0.
REQ-037 Write 0x155 to OUT -> out_pins=0x155 next cycle; read 0x10 returns 0x155.
REQ-038 With the macro: IRQ_MASK=0x000 and STATUS=0x004 -> Intr=1; write IRQ_MASK=0x004 -> Intr=0. Without the macro: read 0x14 returns 0.
